uart_burst_cmd_ctrl: RTL

UART_BURST_CMD_CTRL -- requirements
Module: uart_burst_cmd_ctrl

---
 rtl/sv_defs.sv | 35 +++
 rtl/dbg_timeout_cnt.sv | 30 +++
 rtl/uart_burst_cmd_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sv_defs.sv
`default_nettype none
// ============================================================================
// sv_defs : opcode constants and controller state encoding shared by the
//           UART burst command controller.
// Revision : 1.0
// ============================================================================
package sv_defs;

    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_BURST_WR = 8'h04;
    localparam logic [7:0] OP_BURST_RD = 8'h05;
    localparam logic [7:0] OP_HOLD_SET = 8'h06;
    localparam logic [7:0] OP_HOLD_CLR = 8'h07;
    localparam logic [7:0] OP_FIXED_WR = 8'h08;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        LEN     = 3'd2,
        WDATA   = 3'd3,
        BUS_WR  = 3'd4,
        BUS_RD  = 3'd5,
        TX_SEND = 3'd6,
        TX_WAIT = 3'd7
    } state_t;

    // Opcodes that are followed by address bytes
    function automatic logic is_addr_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_BURST_WR) ||
               (op == OP_BURST_RD) || (op == OP_FIXED_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_timeout_cnt.sv
`default_nettype none
// ============================================================================
// dbg_timeout_cnt : counts quiet cycles; expired flags the TIMEOUT-th one.
// Revision : 1.0
// ============================================================================
module dbg_timeout_cnt #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign expired = !clear && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_burst_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// uart_burst_cmd_ctrl : decodes UART debug commands into single/burst memory
//                       bus accesses and streams read data back to the host.
// Revision : 1.0
// ============================================================================
module uart_burst_cmd_ctrl
    import sv_defs::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_active,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              cpu_hold,
    output logic              busy,
    output logic              cmd_err
);

    localparam int AB   = ADDR_W / 8;
    localparam int AB_W = (AB > 1) ? $clog2(AB) : 1;

    state_t            state, state_next;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr, addr_shifted;
    logic [7:0]        wdata, rdata_q;
    logic [AB_W-1:0]   ab_cnt;
    logic [8:0]        remaining;
    logic              tx_seen;
    logic              hold_q, err_q;
    logic              waiting, timeout_hit, last_ab;

    assign waiting   = (state == ADDR) || (state == LEN) || (state == WDATA);
    assign last_ab   = (ab_cnt == AB_W'(AB - 1));

    dbg_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || !waiting),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        addr_shifted = ADDR_W'({addr, rx_data});
        bus_we       = (state == BUS_WR);
        bus_re       = (state == BUS_RD);
        tx_start     = (state == TX_SEND);
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_valid && is_addr_op(rx_data)) state_next = ADDR;
            end
            ADDR: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (rx_valid && last_ab) begin
                    if (opcode == OP_READ)       state_next = BUS_RD;
                    else if (opcode == OP_WRITE) state_next = WDATA;
                    else                         state_next = LEN;
                end
            end
            LEN: begin
                if (timeout_hit)  state_next = IDLE;
                else if (rx_valid) state_next = (opcode == OP_BURST_RD) ? BUS_RD : WDATA;
            end
            WDATA: begin
                if (timeout_hit)   state_next = IDLE;
                else if (rx_valid) state_next = BUS_WR;
            end
            BUS_WR: begin
                if (bus_ack) state_next = (remaining == 9'd1) ? IDLE : WDATA;
            end
            BUS_RD: begin
                if (bus_ack) state_next = TX_SEND;
            end
            TX_SEND: state_next = TX_WAIT;
            TX_WAIT: begin
                // Re-arm only after the transmitter has visibly taken the byte
                if (tx_seen && !tx_active) state_next = (remaining == 9'd0) ? IDLE : BUS_RD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode    <= '0;
            addr      <= '0;
            wdata     <= '0;
            rdata_q   <= '0;
            ab_cnt    <= '0;
            remaining <= '0;
            tx_seen   <= 1'b0;
            hold_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    ab_cnt <= '0;
                    if (rx_valid) begin
                        opcode <= rx_data;
                        if (rx_data == OP_HOLD_SET)      hold_q <= 1'b1;
                        else if (rx_data == OP_HOLD_CLR) hold_q <= 1'b0;
                        else if (!is_addr_op(rx_data))   err_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else if (rx_valid) begin
                        addr   <= addr_shifted;
                        ab_cnt <= ab_cnt + 1'b1;
                        if (last_ab) remaining <= 9'd1;
                    end
                end
                LEN: begin
                    if (timeout_hit)   err_q <= 1'b1;
                    else if (rx_valid) remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                end
                WDATA: begin
                    if (timeout_hit)   err_q <= 1'b1;
                    else if (rx_valid) wdata <= rx_data;
                end
                BUS_WR: begin
                    if (bus_ack) begin
                        remaining <= remaining - 9'd1;
                        if (opcode == OP_BURST_WR) addr <= addr + 1'b1;
                    end
                end
                BUS_RD: begin
                    if (bus_ack) begin
                        rdata_q   <= bus_rdata;
                        remaining <= remaining - 9'd1;
                        if (opcode == OP_BURST_RD) addr <= addr + 1'b1;
                    end
                end
                TX_SEND: tx_seen <= 1'b0;
                TX_WAIT: begin
                    if (tx_active) tx_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_addr  = addr;
    assign bus_wdata = wdata;
    assign tx_data   = rdata_q;
    assign cpu_hold  = hold_q;
    assign cmd_err   = err_q;

endmodule
`default_nettype wire
